// File: rtl/timer_incr_scheduler.sv
// Timer counter-increment scheduler: edge-detected requests, saturating pending counts, fixed-priority slot grant.
// Optional lost-increment flags enabled by defining TIMER_SCHED_LOST_EN.
module timer_incr_scheduler #(
  parameter int CNT_W = 2
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic [4:0] TREQ,
  input  logic       T6_EN,
  input  logic       SLOT_STB,
  input  logic       INC_OVF,
  input  logic       LOST_CLR,
  output logic       INC_VALID,
  output logic [5:0] INC_SEL,
  output logic [4:0] INC_ADDR,
  output logic       BUSY,
  output logic [5:0] LOST
);

  // state | meaning: S_IDLE wait for slot | S_ISSUE command on outputs | S_SAMPLE capture INC_OVF
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SAMPLE} state_t;

  localparam logic [CNT_W-1:0] PMAX = '1;

  state_t           state;
  logic [CNT_W-1:0] pend     [6];
  logic [CNT_W-1:0] pend_nxt [6];
  logic [4:0]       treq_prev;
  logic [5:0]       inc, dec, sat, gnt_oh, lost_nxt;
  logic [4:0]       gnt_addr;
  logic             granting, t1_granted, busy_nxt;

  always_comb begin
    gnt_oh   = '0;
    gnt_addr = '0;
    // Scan from lowest priority upward so the highest-priority channel is written last.
    for (int i = 5; i >= 0; i--) begin
      if (pend[i] != '0) begin
        gnt_oh   = 6'(1) << i;
        gnt_addr = 5'(20 + i);
      end
    end
    granting = (state == S_IDLE) && SLOT_STB && (gnt_oh != '0);
    dec      = granting ? gnt_oh : 6'b0;
    inc[0]   = (state == S_SAMPLE) && t1_granted && INC_OVF;
    inc[5:1] = TREQ & ~treq_prev & {T6_EN, 4'b1111};
    busy_nxt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sat[i]      = 1'b0;
      pend_nxt[i] = pend[i];
      if (inc[i] && !dec[i]) begin
        if (pend[i] == PMAX) sat[i] = 1'b1;
        else pend_nxt[i] = pend[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        pend_nxt[i] = pend[i] - 1'b1;
      end
    end
    if (!T6_EN) pend_nxt[5] = '0;
    for (int i = 0; i < 6; i++) busy_nxt = busy_nxt | (pend_nxt[i] != '0);
`ifdef TIMER_SCHED_LOST_EN
    lost_nxt = (LOST & ~{6{LOST_CLR}}) | sat;
`else
    lost_nxt = sat & {6{LOST_CLR}} & 6'b0;
`endif
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state      <= S_IDLE;
      pend       <= '{default: '0};
      treq_prev  <= TREQ;
      INC_VALID  <= 1'b0;
      INC_SEL    <= '0;
      INC_ADDR   <= '0;
      BUSY       <= 1'b0;
      LOST       <= '0;
      t1_granted <= 1'b0;
    end else begin
      treq_prev <= TREQ;
      pend      <= pend_nxt;
      BUSY      <= busy_nxt;
      LOST      <= lost_nxt;
      INC_VALID <= 1'b0;
      INC_SEL   <= '0;
      INC_ADDR  <= '0;
      case (state)
        S_IDLE: begin
          if (granting) begin
            INC_VALID  <= 1'b1;
            INC_SEL    <= gnt_oh;
            INC_ADDR   <= gnt_addr;
            t1_granted <= gnt_oh[1];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE:  state <= S_SAMPLE;
        S_SAMPLE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_incr_scheduler.sv
// Directed self-checking bench for timer_incr_scheduler (CNT_W=2).
module tb_timer_incr_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] treq = '0;
  logic       t6_en = 1'b1;
  logic       slot_stb = 1'b0;
  logic       inc_ovf = 1'b0;
  logic       lost_clr = 1'b0;
  logic       inc_valid, busy;
  logic [5:0] inc_sel, lost;
  logic [4:0] inc_addr;
  int errors = 0;
  int checks = 0;
`ifdef TIMER_SCHED_LOST_EN
  localparam logic [5:0] LOST_T4 = 6'b001000;
`else
  localparam logic [5:0] LOST_T4 = 6'b000000;
`endif

  timer_incr_scheduler #(.CNT_W(2)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .TREQ(treq), .T6_EN(t6_en), .SLOT_STB(slot_stb),
    .INC_OVF(inc_ovf), .LOST_CLR(lost_clr), .INC_VALID(inc_valid), .INC_SEL(inc_sel),
    .INC_ADDR(inc_addr), .BUSY(busy), .LOST(lost)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    slot_stb = 1'b1;
    tick();
    slot_stb = 1'b0;
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; treq = 5'b11111;
    tick(); tick();
    checks++; if ({inc_valid, inc_sel, inc_addr, busy, lost} !== 19'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", {inc_valid, inc_sel, inc_addr, busy, lost}); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_held_busy got=%b exp=0", busy); end
    strobe();
    checks++; if (inc_valid !== 1'b0) begin errors++; $display("FAIL reset_held_valid got=%b exp=0", inc_valid); end
    treq = '0;
    settle();
  endtask

  task automatic test_priority();
    treq = 5'b00011;
    tick();
    treq = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy got=%b exp=1", busy); end
    strobe();
    checks++; if (inc_valid !== 1'b1 || inc_sel !== 6'b000010 || inc_addr !== 5'o25) begin errors++; $display("FAIL prio_first got=%b/%b/%o exp=1/000010/25", inc_valid, inc_sel, inc_addr); end
    tick();
    checks++; if (inc_valid !== 1'b0 || inc_sel !== 6'b0 || inc_addr !== 5'b0) begin errors++; $display("FAIL prio_one_cycle got=%b/%b/%o exp=0/0/0", inc_valid, inc_sel, inc_addr); end
    tick();
    strobe();
    checks++; if (inc_valid !== 1'b1 || inc_sel !== 6'b000100 || inc_addr !== 5'o26) begin errors++; $display("FAIL prio_second got=%b/%b/%o exp=1/000100/26", inc_valid, inc_sel, inc_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_drained got=%b exp=0", busy); end
    settle();
  endtask

  task automatic test_same_cycle_edge();
    treq = 5'b00001; slot_stb = 1'b1;
    tick();
    slot_stb = 1'b0;
    checks++; if (inc_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL edge_not_eligible got=%b/%b exp=0/1", inc_valid, busy); end
    treq = '0;
    tick();
    treq = 5'b00001; slot_stb = 1'b1;
    tick();
    slot_stb = 1'b0; treq = '0;
    checks++; if (inc_sel !== 6'b000010 || busy !== 1'b1) begin errors++; $display("FAIL inc_dec_cancel got=%b/%b exp=000010/1", inc_sel, busy); end
    settle();
    strobe();
    checks++; if (inc_sel !== 6'b000010 || busy !== 1'b0) begin errors++; $display("FAIL inc_dec_last got=%b/%b exp=000010/0", inc_sel, busy); end
    settle();
  endtask

  task automatic test_ovf();
    treq = 5'b00001;
    tick();
    treq = '0;
    strobe();
    checks++; if (inc_sel !== 6'b000010) begin errors++; $display("FAIL ovf_t1_grant got=%b exp=000010", inc_sel); end
    tick();
    inc_ovf = 1'b1;
    tick();
    inc_ovf = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_t2_pending got=%b exp=1", busy); end
    strobe();
    checks++; if (inc_valid !== 1'b1 || inc_sel !== 6'b000001 || inc_addr !== 5'o24) begin errors++; $display("FAIL ovf_t2_grant got=%b/%b/%o exp=1/000001/24", inc_valid, inc_sel, inc_addr); end
    settle();
    treq = 5'b00010;
    tick();
    treq = '0;
    strobe();
    tick();
    inc_ovf = 1'b1;
    tick();
    inc_ovf = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_non_t1 got=%b exp=0", busy); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      treq = 5'b00100; tick();
      treq = '0; tick();
    end
    checks++; if (lost !== LOST_T4) begin errors++; $display("FAIL sat_lost got=%b exp=%b", lost, LOST_T4); end
    lost_clr = 1'b1; tick(); lost_clr = 1'b0;
    checks++; if (lost !== 6'b0) begin errors++; $display("FAIL sat_clr got=%b exp=0", lost); end
    treq = 5'b00100; lost_clr = 1'b1; tick();
    treq = '0; lost_clr = 1'b0;
    checks++; if (lost !== LOST_T4) begin errors++; $display("FAIL sat_set_wins got=%b exp=%b", lost, LOST_T4); end
    lost_clr = 1'b1; tick(); lost_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      strobe();
      checks++; if (inc_sel !== 6'b001000 || inc_addr !== 5'o27) begin errors++; $display("FAIL sat_drain%0d got=%b/%o exp=001000/27", k, inc_sel, inc_addr); end
      tick();
    end
    tick();
    strobe();
    checks++; if (inc_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sat_empty got=%b/%b exp=0/0", inc_valid, busy); end
  endtask

  task automatic test_t6();
    t6_en = 1'b1; treq = 5'b10000;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_pending got=%b exp=1", busy); end
    t6_en = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_forced got=%b exp=0", busy); end
    strobe();
    checks++; if (inc_valid !== 1'b0) begin errors++; $display("FAIL t6_no_cmd got=%b exp=0", inc_valid); end
    t6_en = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_reenable got=%b exp=0", busy); end
    treq = '0;
    tick();
    treq = 5'b11000;
    tick();
    treq = '0;
    strobe();
    checks++; if (inc_sel !== 6'b010000 || inc_addr !== 5'o30) begin errors++; $display("FAIL t5_grant got=%b/%o exp=010000/30", inc_sel, inc_addr); end
    settle();
    strobe();
    checks++; if (inc_sel !== 6'b100000 || inc_addr !== 5'o31) begin errors++; $display("FAIL t6_grant got=%b/%o exp=100000/31", inc_sel, inc_addr); end
    settle();
  endtask

  task automatic test_back_to_back_reset();
    treq = 5'b00110;
    tick();
    treq = '0;
    slot_stb = 1'b1;
    tick();
    checks++; if (inc_valid !== 1'b1 || inc_sel !== 6'b000100) begin errors++; $display("FAIL b2b_first got=%b/%b exp=1/000100", inc_valid, inc_sel); end
    tick();
    slot_stb = 1'b0;
    checks++; if (inc_valid !== 1'b0) begin errors++; $display("FAIL b2b_dropped got=%b exp=0", inc_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({inc_valid, inc_sel, inc_addr, busy, lost} !== 19'b0) begin errors++; $display("FAIL b2b_reset got=%b exp=0", {inc_valid, inc_sel, inc_addr, busy, lost}); end
    strobe();
    checks++; if (inc_valid !== 1'b0) begin errors++; $display("FAIL b2b_after_reset got=%b exp=0", inc_valid); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_same_cycle_edge();
    test_ovf();
    test_saturation();
    test_t6();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_incr_scheduler.md
# timer_incr_scheduler

Counter-increment scheduler for the timer section. It turns rising edges from the scaler stage outputs into pending increment requests for TIME1, TIME3, TIME4, TIME5 and TIME6, and queues TIME2 on TIME1 overflow. It arbitrates them by fixed priority onto the single shared increment slot of each memory cycle, and presents the winner to the counter datapath as a one-hot select and an erasable-memory address.

## Interface
- CNT_W, 2: width of each per-channel saturating pending counter; maximum pending is 2^CNT_W-1.
- SIM_CLK  in  1  system clock; all state updates on rising edge.
- SIM_RST  in  1  reset, synchronous, active-high.
- TREQ  in  5  request lines from scaler stages, rising-edge sensitive: [0]=TIME1, [1]=TIME3, [2]=TIME4, [3]=TIME5, [4]=TIME6.
- T6_EN  in  1  TIME6 enable; when low, TREQ[4] edges are ignored.
- SLOT_STB  in  1  one-cycle strobe marking the increment slot of a memory cycle.
- INC_OVF  in  1  datapath overflow flag, sampled one cycle after INC_VALID.
- LOST_CLR  in  1  clears all LOST flags.
- INC_VALID  out  1  one-cycle increment command.
- INC_SEL  out  6  one-hot channel: [0]=TIME2, [1]=TIME1, [2]=TIME3, [3]=TIME4, [4]=TIME5, [5]=TIME6.
- INC_ADDR  out  5  counter address: TIME2=5'o24, TIME1=5'o25, TIME3=5'o26, TIME4=5'o27, TIME5=5'o30, TIME6=5'o31.
- BUSY  out  1  any pending counter nonzero.
- LOST  out  6  sticky per-channel lost-increment flags, same bit order as INC_SEL.

## Operation
- Edge detect: a per-line previous-value register. An edge is TREQ[i] high while the previous value is low.
- Pending: each of the 6 channels has a CNT_W-bit counter. An edge increments it. A grant decrements it. If both happen in the same cycle, the counter is unchanged. The counter saturates at maximum.
- Edge at saturation: the count is held. With the macro enabled, LOST[i] is set.
- TIME2 source: INC_OVF is sampled one cycle after an INC_VALID whose INC_SEL[1] was set. If it is high, TIME2 pending is incremented. No other source feeds TIME2.
- T6_EN low: TIME6 pending is forced to 0 and TREQ[4] edges are discarded. The edge register still tracks TREQ[4], so raising T6_EN while TREQ[4] is high produces no edge.
- Arbitration: on SLOT_STB while not blocked, the lowest-index nonzero channel wins. Priority order is TIME2 > TIME1 > TIME3 > TIME4 > TIME5 > TIME6. The decision uses registered pending values only; an edge arriving in the strobe cycle is not eligible in that slot.
- If no channel is pending at SLOT_STB, no command is issued.
- Blocking: SLOT_STB is ignored during the 2 cycles following a grant (the INC_VALID cycle and the INC_OVF sample cycle).
- State machine:
  - IDLE: on SLOT_STB with pending, go to ISSUE.
  - ISSUE: drive INC_VALID, INC_SEL and INC_ADDR for 1 cycle, then go to SAMPLE.
  - SAMPLE: capture INC_OVF if the grant was TIME1, then return to IDLE.

## Timing
- SLOT_STB at cycle n with pending → INC_VALID, INC_SEL, INC_ADDR valid at n+1 only; INC_SEL and INC_ADDR are 0 otherwise.
- Pending decrement is visible at n+1.
- INC_OVF is sampled at n+2; resulting TIME2 pending is visible at n+3 and eligible from the next SLOT_STB.
- Minimum useful strobe spacing is 3 cycles. Strobes at n+1 and n+2 are dropped.
- TREQ edge at cycle m → pending visible at m+1; BUSY updates at the same edge.
- Reset, in any state including mid-ISSUE or mid-SAMPLE:
  - FSM to IDLE; all pending counters to 0.
  - INC_VALID, INC_SEL, INC_ADDR, LOST to 0; BUSY to 0.
  - Edge registers load current TREQ, so lines held high through reset produce no edge.
  - A pending INC_OVF sample is discarded.
- LOST_CLR and a same-cycle saturation event on the same channel: the set wins.

## Configuration
- TIMER_SCHED_LOST_EN defined: LOST flags and LOST_CLR are implemented as specified.
- TIMER_SCHED_LOST_EN undefined: LOST is tied to 6'b0, LOST_CLR is ignored, and saturation silently drops edges.

## Test plan
- Reset with TREQ=5'b11111 held high, release, then SLOT_STB → no INC_VALID, BUSY=0.
- TREQ[1] and TREQ[0] edges in the same cycle, then SLOT_STB at 3-cycle spacing → first command INC_SEL=6'b000010 with INC_ADDR=5'o25, second INC_SEL=6'b000100 with INC_ADDR=5'o26, then BUSY=0.
- TIME1 grant with INC_OVF=1 at n+2, then SLOT_STB at n+3 → INC_SEL=6'b000001, INC_ADDR=5'o24.
- 4 TREQ[2] edges with CNT_W=2 and no strobes → pending 3, LOST[3]=1 (macro on); LOST_CLR → LOST=0; 3 strobes drain the channel.
- TREQ[4] edge with T6_EN=1, then T6_EN→0, then SLOT_STB → no command; raise T6_EN with TREQ[4] held high → no pending.
- SLOT_STB at n with TIME3 pending, second SLOT_STB at n+1, reset asserted at n+2 → exactly one INC_VALID at n+1; all outputs 0 after reset.
